// File: rtl/dfr_pkg.sv
// Shared types and constants for the DFR phase sequencer and its nested counter.
package dfr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_OL_WAIT = 3'd5,
        ST_DONE    = 3'd6
    } dfr_seq_state_t;

    typedef enum logic [1:0] {
        PH_INIT  = 2'd0,
        PH_TRAIN = 2'd1,
        PH_TEST  = 2'd2
    } dfr_phase_t;

    localparam int CTRL_START    = 0;
    localparam int CTRL_BUSY     = 1;
    localparam int CTRL_PRESERVE = 2;

    // Returns {found, phase}: the lowest non-empty phase at or after 'from'.
    function automatic logic [2:0] pick_phase(input logic [2:0] nonempty, input logic [1:0] from);
        logic [2:0] sel;
        sel = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (i >= int'(from) && nonempty[i]) sel = {1'b1, 2'(i)};
        end
        return sel;
    endfunction

endpackage

// File: rtl/dfr_seq_counter.sv
// Step/sample nested counter; load zeroes both indices and captures the limits for a phase.
module dfr_seq_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] num_steps,
    input  logic [CNT_W-1:0] num_samples,
    output logic [CNT_W-1:0] sample_idx,
    output logic             last_step,
    output logic             last_sample
);

    logic [CNT_W-1:0] step_idx;
    logic [CNT_W-1:0] steps_q;
    logic [CNT_W-1:0] samples_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_idx   <= '0;
            sample_idx <= '0;
            steps_q    <= '0;
            samples_q  <= '0;
        end else if (load) begin
            step_idx   <= '0;
            sample_idx <= '0;
            steps_q    <= num_steps;
            samples_q  <= num_samples;
        end else if (en) begin
            if (last_step) begin
                step_idx   <= '0;
                sample_idx <= sample_idx + CNT_W'(1);
            end else begin
                step_idx <= step_idx + CNT_W'(1);
            end
        end
    end

    assign last_step   = (step_idx == steps_q - CNT_W'(1));
    assign last_sample = (sample_idx == samples_q - CNT_W'(1));

endmodule

// File: rtl/dfr_sequencer.sv
// Walks the DFR reservoir through init/train/test phases and hands test samples to the output layer.
//
// state    | meaning
// IDLE     | waiting for start; config latched on start
// CHECK    | validate step total against the address space
// CLEAR    | optional reservoir clear, load counter for first phase
// RUN      | one input read per cycle, global step address advancing
// DRAIN    | final res_step/history write of a segment retires
// OL_WAIT  | output layer launched for one test sample, await ol_done
// DONE     | one-cycle completion pulse
module dfr_sequencer
    import dfr_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              preserve,
    input  logic [CNT_W-1:0]  num_init_samples,
    input  logic [CNT_W-1:0]  num_train_samples,
    input  logic [CNT_W-1:0]  num_test_samples,
    input  logic [CNT_W-1:0]  num_steps_per_sample,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_rd_addr,
    output logic              res_clear,
    output logic              res_step,
    output logic              hist_wr_en,
    output logic [ADDR_W-1:0] hist_wr_addr,
    output logic              ol_start,
    output logic [CNT_W-1:0]  ol_sample_idx,
    input  logic              ol_done,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [2:0]        dbg_phase
);

    localparam int SUM_W  = CNT_W + 2;
    localparam int PROD_W = SUM_W + CNT_W;
    localparam logic [PROD_W-1:0] STEP_LIMIT = PROD_W'(1) << ADDR_W;

    dfr_seq_state_t    state_q, state_d;
    dfr_phase_t        phase_q, phase_d;
    logic [CNT_W-1:0]  init_q, train_q, test_q, steps_q;
    logic              preserve_q;
    logic              cfg_err_q;
    logic [ADDR_W-1:0] rd_addr_q, hist_addr_q;
    logic              res_step_q, hist_pend_q, ol_start_q, ol_last_q;
    logic [CNT_W-1:0]  ol_idx_q;

    logic              start_acc, chk_err, ol_latch;
    logic              cnt_load, cnt_en;
    logic [1:0]        ld_phase;
    logic [CNT_W-1:0]  cnt_ld_samples;
    logic [CNT_W-1:0]  cnt_sample_idx;
    logic              cnt_last_step, cnt_last_sample;

    logic [SUM_W-1:0]  sample_sum;
    logic [PROD_W-1:0] step_total;
    logic [2:0]        nonempty;
    logic [2:0]        first_sel, next_sel;

    assign sample_sum = SUM_W'(init_q) + SUM_W'(train_q) + SUM_W'(test_q);
    assign step_total = PROD_W'(sample_sum) * PROD_W'(steps_q);
    assign nonempty   = {test_q != '0, train_q != '0, init_q != '0};
    assign first_sel  = pick_phase(nonempty, 2'd0);
    assign next_sel   = pick_phase(nonempty, phase_q + 2'd1);

    dfr_seq_counter #(.CNT_W(CNT_W)) u_counter (
        .clk         (clk),
        .rst         (rst),
        .load        (cnt_load),
        .en          (cnt_en),
        .num_steps   (steps_q),
        .num_samples (cnt_ld_samples),
        .sample_idx  (cnt_sample_idx),
        .last_step   (cnt_last_step),
        .last_sample (cnt_last_sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_INIT;
            init_q      <= '0;
            train_q     <= '0;
            test_q      <= '0;
            steps_q     <= '0;
            preserve_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            rd_addr_q   <= '0;
            hist_addr_q <= '0;
            res_step_q  <= 1'b0;
            hist_pend_q <= 1'b0;
            ol_start_q  <= 1'b0;
            ol_idx_q    <= '0;
            ol_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            res_step_q  <= (state_q == ST_RUN);
            hist_pend_q <= (state_q == ST_RUN) && (phase_q != PH_INIT);
            ol_start_q  <= (state_q == ST_DRAIN) && (phase_q == PH_TEST);
            if (start_acc) begin
                init_q      <= num_init_samples;
                train_q     <= num_train_samples;
                test_q      <= num_test_samples;
                steps_q     <= num_steps_per_sample;
                preserve_q  <= preserve;
                cfg_err_q   <= 1'b0;
                rd_addr_q   <= '0;
                hist_addr_q <= '0;
            end
            if (chk_err) cfg_err_q <= 1'b1;
            if (state_q == ST_RUN) rd_addr_q <= rd_addr_q + ADDR_W'(1);
            if (hist_pend_q) hist_addr_q <= hist_addr_q + ADDR_W'(1);
            // Sample index must be captured before the counter advances past it.
            if (ol_latch) begin
                ol_idx_q  <= cnt_sample_idx;
                ol_last_q <= cnt_last_sample;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        start_acc      = 1'b0;
        chk_err        = 1'b0;
        ol_latch       = 1'b0;
        cnt_load       = 1'b0;
        cnt_en         = 1'b0;
        ld_phase       = first_sel[1:0];
        cnt_ld_samples = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (steps_q == '0 || step_total > STEP_LIMIT) begin
                    chk_err = 1'b1;
                    state_d = ST_DONE;
                end else if (sample_sum == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_load = 1'b1;
                phase_d  = dfr_phase_t'(first_sel[1:0]);
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (cnt_last_step && phase_q == PH_TEST) begin
                    ol_latch = 1'b1;
                    state_d  = ST_DRAIN;
                end else if (cnt_last_step && cnt_last_sample) begin
                    if (next_sel[2]) begin
                        cnt_load = 1'b1;
                        ld_phase = next_sel[1:0];
                        phase_d  = dfr_phase_t'(next_sel[1:0]);
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN:   state_d = (phase_q == PH_TEST) ? ST_OL_WAIT : ST_DONE;
            ST_OL_WAIT: if (ol_done) state_d = ol_last_q ? ST_DONE : ST_RUN;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        case (ld_phase)
            2'd0:    cnt_ld_samples = init_q;
            2'd1:    cnt_ld_samples = train_q;
            2'd2:    cnt_ld_samples = test_q;
            default: cnt_ld_samples = '0;
        endcase
    end

    assign in_rd_en      = (state_q == ST_RUN);
    assign in_rd_addr    = rd_addr_q;
    assign res_clear     = (state_q == ST_CLEAR) && !preserve_q;
    assign res_step      = res_step_q;
    assign hist_wr_en    = hist_pend_q;
    assign hist_wr_addr  = hist_addr_q;
    assign ol_start      = ol_start_q;
    assign ol_sample_idx = ol_idx_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign cfg_err       = cfg_err_q;
    assign dbg_phase     = state_q;

endmodule
